usr_seq_ctrl: RTL and testbench
===============================

Name: usr_seq_ctrl

Overview:
- Command sequencer for the 4-bit universal shift register (`usr`).
- Accepts one command at a time: parallel load, shift left N, shift right N, or no-op.
- Drives the `usr` mode-select, parallel and serial inputs; supplies serial fill bits from a valid/ready bit stream.
- Captures the bits shifted out and signals completion with a one-cycle `done` pulse.
- Sits between a host or test driver and the `usr` instance; both share `clk` and `reset`.

Parameters:
- WIDTH, 4, register width; must match the `usr` instance.
- CNT_W, 3, width of the shift-count field; maximum shift count is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 NOP, 01 SHR, 10 SHL, 11 LOAD.
- cmd_data  input  WIDTH  parallel word for LOAD.
- cmd_count  input  CNT_W  number of shifts for SHR/SHL.
- ser_in  input  1  serial fill bit.
- ser_valid  input  1  `ser_in` is valid.
- ser_ready  output  1  fill bit consumed this cycle.
- usr_sel  output  2  to `usr` `sel`: 00 hold, 01 shift right, 10 shift left, 11 load.
- usr_data_in  output  WIDTH  to `usr` `data_in`.
- usr_shift_left_data  output  1  to `usr`; serial fill for left shift, enters at LSB.
- usr_shift_right_data  output  1  to `usr`; serial fill for right shift, enters at MSB.
- usr_shift_left_out  input  1  from `usr`; current MSB.
- usr_shift_right_out  input  1  from `usr`; current LSB.
- busy  output  1  controller is not in IDLE.
- done  output  1  one-cycle completion pulse.
- cap_data  output  WIDTH  bits shifted out by the last command.

Behaviour:

Reset (asynchronous, immediate, including mid-command):
- state goes to IDLE.
- usr_sel=00, usr_data_in=0, both serial-data outputs 0.
- cap_data=0, done=0, busy=0, ser_ready=0.
- cmd_ready=1 from the first clk edge after reset is released.
- Any in-flight command is dropped. `usr` content is governed by its own reset.

States: IDLE, LOAD, SHIFT, DONE.

IDLE:
- cmd_ready=1, usr_sel=00.
- Accept occurs on a clk edge with cmd_valid=1. On accept, register op, data and count, and clear cap_data to 0.
- Next state:
  - LOAD if op=11.
  - SHIFT if op is 01 or 10 and count>0.
  - DONE if op=00, or if op is 01/10 with count=0.

LOAD:
- Exactly one cycle with usr_sel=11 and usr_data_in = registered data.
- `usr` loads on the edge that leaves LOAD; next state DONE.

SHIFT:
- If ser_valid=1:
  - usr_sel = op, ser_ready=1.
  - The serial-data output for the active direction = ser_in (combinational); the other serial output = 0.
  - On the edge: `usr` shifts; remaining count decrements.
  - SHR capture: cap_data <= {usr_shift_right_out, cap_data[WIDTH-1:1]}.
  - SHL capture: cap_data <= {cap_data[WIDTH-2:0], usr_shift_left_out}.
  - The captured bit is the pre-edge value.
- If ser_valid=0 (stall): usr_sel=00, ser_ready=0; count and cap_data unchanged.
- Leave to DONE on the edge where the final shift occurs (remaining was 1).

DONE:
- Exactly one cycle: done=1, usr_sel=00; next state IDLE.

General rules:
- cap_data holds its value until the next accept.
- busy = (state != IDLE).
- cmd_valid outside IDLE is ignored; the command must be held until accepted.
- Latency from accept edge to done high:
  - NOP / count=0: 1 cycle.
  - LOAD: 2 cycles.
  - Shift of N with no stalls: N+1 cycles.
- Counts ≥ WIDTH are legal. Shifting continues; cap_data keeps the last WIDTH bits out.
- ser_ready is never high outside SHIFT.

Test Plan (WIDTH=4; bench instantiates `usr` and `usr_seq_ctrl` on a common clk/reset):
1. LOAD cmd_data=1011 → usr_sel=11 for exactly one cycle; `usr` parallel_data=1011 after that edge; done pulses 2 cycles after accept; cmd_ready=1 again on the following cycle.
2. From 1011, SHR count=2, ser_in stream 1 then 0, ser_valid held 1 → parallel_data goes 1101 then 0110; cap_data=1100 at done; exactly 2 ser_ready pulses.
3. From 1011, SHL count=3, ser_in 0,0,1, with ser_valid dropped for 2 cycles after the first shift → parallel_data goes 0110, then holds for 2 cycles, then 1100, then 1001; cap_data=0101; usr_sel=00 during the stall; done at accept+6.
4. NOP, and SHR with count=0 → usr_sel never leaves 00; ser_ready stays 0; done one cycle after accept; cap_data=0000.
5. Assert reset mid-SHIFT (count=5, after 2 shifts) → same cycle: usr_sel=00, done=0, busy=0, cap_data=0; after release, cmd_ready=1 and a new LOAD 0101 completes normally.
6. Back-to-back: cmd_valid held high with a second command while busy → second command accepted only on the cycle after done; no command lost or duplicated.

Source files
------------

// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usr_seq_ctrl
// Description : Command sequencer for the 4-bit universal shift register.
//               Drives load/shift steps and captures shifted-out bits.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_data_in,
    output logic             usr_shift_left_data,
    output logic             usr_shift_right_data,
    input  logic             usr_shift_left_out,
    input  logic             usr_shift_right_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cap_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       C_OP_SHR  = 2'b01;
    localparam logic [1:0]       C_OP_SHL  = 2'b10;
    localparam logic [1:0]       C_OP_LOAD = 2'b11;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q;

    // armed_q keeps cmd_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            data_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d              = state_q;
        op_d                 = op_q;
        data_d               = data_q;
        cap_d                = cap_q;
        cnt_d                = cnt_q;
        cmd_ready            = 1'b0;
        ser_ready            = 1'b0;
        usr_sel              = 2'b00;
        usr_data_in          = '0;
        usr_shift_left_data  = 1'b0;
        usr_shift_right_data = 1'b0;
        done                 = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = armed_q;
                if (armed_q && cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    cnt_d  = cmd_count;
                    cap_d  = '0;
                    if (cmd_op == C_OP_LOAD)
                        state_d = S_LOAD;
                    else if ((cmd_op == C_OP_SHR || cmd_op == C_OP_SHL) && cmd_count != '0)
                        state_d = S_SHIFT;
                    else
                        state_d = S_DONE;
                end
            end
            S_LOAD: begin
                usr_sel     = 2'b11;
                usr_data_in = data_q;
                state_d     = S_DONE;
            end
            S_SHIFT: begin
                if (ser_valid) begin
                    usr_sel   = op_q;
                    ser_ready = 1'b1;
                    // captured bit is the register's edge-side bit before it moves
                    if (op_q == C_OP_SHR) begin
                        usr_shift_right_data = ser_in;
                        cap_d = {usr_shift_right_out, cap_q[WIDTH-1:1]};
                    end else begin
                        usr_shift_left_data = ser_in;
                        cap_d = {cap_q[WIDTH-2:0], usr_shift_left_out};
                    end
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign cap_data = cap_q;

endmodule
`default_nettype wire

// File: tb/tb_usr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_seq_ctrl
// Description : Self-checking bench for usr_seq_ctrl with a behavioural usr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [2:0] cmd_count = 3'd0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_ready;
    logic [1:0] usr_sel;
    logic [3:0] usr_data_in;
    logic       usr_shift_left_data;
    logic       usr_shift_right_data;
    logic       usr_shift_left_out;
    logic       usr_shift_right_out;
    logic       busy;
    logic       done;
    logic [3:0] cap_data;

    usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_data             (cmd_data),
        .cmd_count            (cmd_count),
        .ser_in               (ser_in),
        .ser_valid            (ser_valid),
        .ser_ready            (ser_ready),
        .usr_sel              (usr_sel),
        .usr_data_in          (usr_data_in),
        .usr_shift_left_data  (usr_shift_left_data),
        .usr_shift_right_data (usr_shift_right_data),
        .usr_shift_left_out   (usr_shift_left_out),
        .usr_shift_right_out  (usr_shift_right_out),
        .busy                 (busy),
        .done                 (done),
        .cap_data             (cap_data)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the usr register the controller drives
    logic [3:0] usr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) usr_q <= 4'h0;
        else begin
            case (usr_sel)
                2'b01:   usr_q <= {usr_shift_right_data, usr_q[3:1]};
                2'b10:   usr_q <= {usr_q[2:0], usr_shift_left_data};
                2'b11:   usr_q <= usr_data_in;
                default: usr_q <= usr_q;
            endcase
        end
    end
    assign usr_shift_left_out  = usr_q[3];
    assign usr_shift_right_out = usr_q[0];

    int n_checks = 0;
    int n_fail   = 0;
    int ref_reg  = 0;
    int valid_pct = 100;
    bit fill_q[$];
    bit stall_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input bit chained, input bit hold_next,
                           input logic [1:0] nop, input logic [3:0] ndata, input logic [2:0] ncnt);
        int  waitc, rem, lat, pulses, stalls, n, shift_n, exp_lat;
        bit  is_shift, load_pending, seen_done, sv, si, ob;
        bit  outs[$];
        int  exp_cap;
        is_shift = (op == 2'b01 || op == 2'b10);
        shift_n  = is_shift ? int'(cnt) : 0;
        @(negedge clk);
        if (!chained) begin
            cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
        end
        ser_valid = 1'($urandom_range(1));
        #1;
        if (chained) check("b2b_ready", int'(cmd_ready), 1);
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk); #1; waitc++;
        end
        if (waitc >= 20) begin
            check("accept_timeout", 0, 1);
            return;
        end
        check("idle_ser_ready", int'(ser_ready), 0);
        @(posedge clk); #1;
        if (hold_next) begin
            cmd_op = nop; cmd_data = ndata; cmd_count = ncnt;
        end else cmd_valid = 1'b0;

        rem = shift_n; load_pending = (op == 2'b11);
        lat = 0; pulses = 0; stalls = 0; seen_done = 0;
        while (!seen_done && lat < 60) begin
            @(negedge clk);
            lat++;
            sv = (stall_q.size() > 0) ? stall_q.pop_front() : ($urandom_range(99) < valid_pct);
            si = (fill_q.size() > 0) ? fill_q[0] : 1'($urandom_range(1));
            ser_valid = sv; ser_in = si;
            #1;
            check("busy", int'(busy), 1);
            check("ready_while_busy", int'(cmd_ready), 0);
            if (load_pending) begin
                check("load_sel", int'(usr_sel), 3);
                check("load_data", int'(usr_data_in), int'(data));
                check("load_ser_ready", int'(ser_ready), 0);
                ref_reg = int'(data);
                load_pending = 0;
            end else if (rem > 0) begin
                check("shift_done_early", int'(done), 0);
                if (sv) begin
                    check("step_ser_ready", int'(ser_ready), 1);
                    check("step_sel", int'(usr_sel), int'(op));
                    if (op == 2'b01) begin
                        check("shr_fill", int'(usr_shift_right_data), int'(si));
                        check("shr_other", int'(usr_shift_left_data), 0);
                        ob = ref_reg[0];
                        ref_reg = (ref_reg >> 1) | (int'(si) << 3);
                    end else begin
                        check("shl_fill", int'(usr_shift_left_data), int'(si));
                        check("shl_other", int'(usr_shift_right_data), 0);
                        ob = ref_reg[3];
                        ref_reg = ((ref_reg << 1) & 15) | int'(si);
                    end
                    outs.push_back(ob);
                    if (fill_q.size() > 0) void'(fill_q.pop_front());
                    rem--; pulses++;
                end else begin
                    check("stall_ser_ready", int'(ser_ready), 0);
                    check("stall_sel", int'(usr_sel), 0);
                    stalls++;
                end
            end else begin
                check("done", int'(done), 1);
                check("done_sel", int'(usr_sel), 0);
                check("done_ser_ready", int'(ser_ready), 0);
                seen_done = 1;
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
        exp_lat = (op == 2'b11) ? 2 : shift_n + stalls + 1;
        check("latency", lat, exp_lat);
        check("ser_pulses", pulses, shift_n);
        exp_cap = 0;
        n = outs.size();
        for (int j = 0; j < 4 && j < n; j++) begin
            if (op == 2'b01) exp_cap = exp_cap | (int'(outs[n-1-j]) << (3 - j));
            else             exp_cap = exp_cap | (int'(outs[n-1-j]) << j);
        end
        check("cap_data", int'(cap_data), exp_cap);
        check("usr_content", int'(usr_q), ref_reg);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    logic [1:0] c_op, n_op;
    logic [3:0] c_dat, n_dat;
    logic [2:0] c_cnt, n_cnt;
    bit         chn, hn;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); ser_valid = 1'b1; #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sel", int'(usr_sel), 0);
        check("rst_cap", int'(cap_data), 0);
        check("rst_ser_ready", int'(ser_ready), 0);
        check("rst_data_in", int'(usr_data_in), 0);
        @(negedge clk); reset = 1'b0; ser_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", int'(cmd_ready), 1);

        // Load, then directed right and left shifts from 1011
        valid_pct = 100;
        run_cmd(2'b11, 4'b1011, 3'd0, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t1_usr", int'(usr_q), 4'b1011);
        fill_q = '{1'b1, 1'b0};
        run_cmd(2'b01, 4'h0, 3'd2, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t2_usr", int'(usr_q), 4'b0110);
        check("t2_cap", int'(cap_data), 4'b1100);
        run_cmd(2'b11, 4'b1011, 3'd0, 0, 0, 2'b00, 4'h0, 3'd0);
        fill_q = '{1'b0, 1'b0, 1'b1};
        stall_q = '{1'b1, 1'b0, 1'b0};
        run_cmd(2'b10, 4'h0, 3'd3, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t3_usr", int'(usr_q), 4'b1001);
        check("t3_cap", int'(cap_data), 4'b0101);

        // NOP and zero-count shift
        run_cmd(2'b00, 4'hF, 3'd5, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t4_nop_cap", int'(cap_data), 0);
        run_cmd(2'b01, 4'hF, 3'd0, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t4_shr0_cap", int'(cap_data), 0);

        // Reset in the middle of a 5-step shift
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd5; ser_valid = 1'b0;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk); ser_valid = 1'b1; ser_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        check("t5_sel", int'(usr_sel), 0);
        check("t5_done", int'(done), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_cap", int'(cap_data), 0);
        check("t5_ser_ready", int'(ser_ready), 0);
        @(negedge clk); reset = 1'b0; ser_valid = 1'b0; ref_reg = 0;
        @(posedge clk); #1;
        check("t5_ready", int'(cmd_ready), 1);
        run_cmd(2'b11, 4'b0101, 3'd0, 0, 0, 2'b00, 4'h0, 3'd0);
        check("t5_usr", int'(usr_q), 4'b0101);

        // Back-to-back: second command held valid while the first runs
        run_cmd(2'b11, 4'b0011, 3'd0, 0, 1, 2'b10, 4'h0, 3'd2);
        run_cmd(2'b10, 4'h0, 3'd2, 1, 0, 2'b00, 4'h0, 3'd0);

        // Randomised command stream with stalls and chaining
        c_op = 2'($urandom_range(3)); c_dat = 4'($urandom_range(15)); c_cnt = 3'($urandom_range(7));
        chn = 0;
        for (int i = 0; i < 40; i++) begin
            valid_pct = 40 + int'($urandom_range(60));
            n_op = 2'($urandom_range(3)); n_dat = 4'($urandom_range(15)); n_cnt = 3'($urandom_range(7));
            hn = (i < 39) && ($urandom_range(1) == 1);
            run_cmd(c_op, c_dat, c_cnt, chn, hn, n_op, n_dat, n_cnt);
            chn = hn; c_op = n_op; c_dat = n_dat; c_cnt = n_cnt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
